// File: rtl/axi_lite_dmem_if.sv
// AXI4-lite bus bundle for the data memory.
//   slave  : memory side (axi_lite_dmem)
//   master : requester side (CPU core / testbench)
// Signals: AW (awvalid/awready/awaddr/awprot), W (wvalid/wready/wdata/wstrb),
//          B (bvalid/bready/bresp), AR (arvalid/arready/araddr/arprot),
//          R (rvalid/rready/rdata/rresp).
interface axi_lite_dmem_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_dmem.sv
// AXI4-lite slave data memory: word-organised synchronous RAM with byte-strobe writes.
// Independent read and write channels, one outstanding transaction per direction.
// Out-of-range accesses complete with SLVERR (writes are dropped, reads return 0).
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset (RAM contents are not reset)
//   axi   : AXI4-lite slave bundle (see axi_lite_dmem_if)
// Parameters:
//   DEPTH_LOG2 : log2 of the number of 32-bit words
//   BASE_ADDR  : byte address of word 0, aligned to 4*2**DEPTH_LOG2
module axi_lite_dmem #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  axi_lite_dmem_if.slave axi
);

  localparam int unsigned Depth  = 2 ** DEPTH_LOG2;
  localparam logic [1:0]  Okay   = 2'b00;
  localparam logic [1:0]  SlvErr = 2'b10;

  typedef enum logic [1:0] {RIdle, RMem, RResp} r_state_e;

  // Word offset from the base; BASE_ADDR is word aligned so the byte lanes drop out.
  function automatic logic [29:0] f_word_off(logic [31:0] addr);
    return addr[31:2] - BASE_ADDR[31:2];
  endfunction

  function automatic logic f_in_range(logic [31:0] addr);
    return (f_word_off(addr) >> DEPTH_LOG2) == 30'd0;
  endfunction

  logic [31:0] r_mem [Depth];

  // Write channel state
  logic        r_aw_held;
  logic        r_w_held;
  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_bvalid;
  logic [1:0]  r_bresp;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_commit;
  logic [31:0]           w_wr_addr;
  logic [31:0]           w_wr_data;
  logic [3:0]            w_wr_strb;
  logic                  w_wr_in_range;
  logic [DEPTH_LOG2-1:0] w_wr_idx;
  logic [29:0]           w_wr_off;

  // Read channel state
  r_state_e    r_state;
  r_state_e    w_state_next;
  logic [31:0] r_araddr;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        w_arready;
  logic        w_rvalid;
  logic        w_rd_in_range;
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic [29:0]           w_rd_off;

  logic w_unused_bits;
  assign w_unused_bits = ^{axi.awprot, axi.arprot, axi.awaddr[1:0], axi.araddr[1:0],
                           w_wr_off, w_rd_off};

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  assign axi.awready = !r_aw_held && !r_bvalid;
  assign axi.wready  = !r_w_held && !r_bvalid;
  assign axi.bvalid  = r_bvalid;
  assign axi.bresp   = r_bresp;

  assign w_aw_hs = axi.awvalid && axi.awready;
  assign w_w_hs  = axi.wvalid && axi.wready;

  // Commit as soon as both halves are available, whether held or arriving this cycle.
  assign w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_wr_addr = r_aw_held ? r_awaddr : axi.awaddr;
  assign w_wr_data = r_w_held ? r_wdata : axi.wdata;
  assign w_wr_strb = r_w_held ? r_wstrb : axi.wstrb;

  assign w_wr_in_range = f_in_range(w_wr_addr);
  assign w_wr_off      = f_word_off(w_wr_addr);
  assign w_wr_idx      = w_wr_off[DEPTH_LOG2-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= Okay;
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b1;
      r_bresp   <= w_wr_in_range ? Okay : SlvErr;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= axi.awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= axi.wdata;
        r_wstrb  <= axi.wstrb;
      end
      if (r_bvalid && axi.bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && w_wr_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wr_strb[b]) begin
          r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  assign axi.arready = w_arready;
  assign axi.rvalid  = w_rvalid;
  assign axi.rdata   = r_rdata;
  assign axi.rresp   = r_rresp;

  assign w_rd_in_range = f_in_range(r_araddr);
  assign w_rd_off      = f_word_off(r_araddr);
  assign w_rd_idx      = w_rd_off[DEPTH_LOG2-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RIdle;
      r_araddr <= '0;
      r_rdata  <= '0;
      r_rresp  <= Okay;
    end else begin
      r_state <= w_state_next;
      if (r_state == RIdle && axi.arvalid) begin
        r_araddr <= axi.araddr;
      end
      // RAM read sees the array before this edge's write lands (read-first).
      if (r_state == RMem) begin
        r_rdata <= w_rd_in_range ? r_mem[w_rd_idx] : 32'h0;
        r_rresp <= w_rd_in_range ? Okay : SlvErr;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_arready    = 1'b0;
    w_rvalid     = 1'b0;
    unique case (r_state)
      RIdle: begin
        w_arready = 1'b1;
        if (axi.arvalid) begin
          w_state_next = RMem;
        end
      end
      RMem: begin
        w_state_next = RResp;
      end
      RResp: begin
        w_rvalid = 1'b1;
        if (axi.rready) begin
          w_state_next = RIdle;
        end
      end
      default: begin
        w_state_next = RIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_lite_dmem.sv
// Self-checking bench for axi_lite_dmem: directed scenarios plus randomized traffic
// checked against an array-based memory model.
module tb_axi_lite_dmem;

  localparam int unsigned DL2  = 6;
  localparam int unsigned NW   = 64;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] model [NW];

  axi_lite_dmem_if axi ();

  axi_lite_dmem #(
    .DEPTH_LOG2(DL2),
    .BASE_ADDR (BASE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .axi  (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit in_rng(logic [31:0] a);
    longint ua;
    ua = longint'(a);
    return (ua >= longint'(BASE)) && (ua < longint'(BASE) + 4 * NW);
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  function automatic void model_write(logic [31:0] a, logic [31:0] d, logic [3:0] s);
    if (in_rng(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
      end
    end
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a);
    return in_rng(a) ? model[widx(a)] : 32'h0;
  endfunction

  function automatic logic [1:0] exp_resp(logic [31:0] a);
    return in_rng(a) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] rand_in_addr();
    return BASE + 4 * $urandom_range(0, NW - 1) + ($urandom() % 4);
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_bus(input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int bdly,
                        output logic [1:0] resp, output int lat);
    int n = 0;
    axi.awvalid = 1'b1;
    axi.awaddr  = addr;
    axi.wvalid  = 1'b1;
    axi.wdata   = data;
    axi.wstrb   = strb;
    while (!(axi.awready === 1'b1 && axi.wready === 1'b1) && n < 20) begin
      tick();
      n++;
    end
    tick();
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    lat = 1;
    while (axi.bvalid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    if (axi.bvalid !== 1'b1 || n >= 20) lat = -1;
    repeat (bdly) tick();
    resp = axi.bresp;
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
  endtask

  task automatic rd_bus(input logic [31:0] addr, input int rdly,
                        output logic [31:0] data, output logic [1:0] resp, output int lat);
    int n = 0;
    axi.arvalid = 1'b1;
    axi.araddr  = addr;
    while (axi.arready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tick();
    axi.arvalid = 1'b0;
    lat = 1;
    while (axi.rvalid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    if (axi.rvalid !== 1'b1 || n >= 20) lat = -1;
    repeat (rdly) tick();
    data = axi.rdata;
    resp = axi.rresp;
    axi.rready = 1'b1;
    tick();
    axi.rready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [8:0] got;
    got = {axi.bvalid, axi.rvalid, axi.bresp, axi.rresp, axi.awready, axi.wready, axi.arready};
    checks++;
    if (got !== 9'b0_0_00_00_111) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp %b", got, 9'b0_0_00_00_111);
    end
    checks++;
    if (axi.rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h exp 00000000", axi.rdata);
    end
  endtask

  task automatic test_fill();
    logic [1:0]  r;
    logic [31:0] d;
    int          lat;
    for (int i = 0; i < NW; i++) begin
      d = $urandom();
      wr_bus(BASE + 4 * i, d, 4'hf, 0, r, lat);
      model_write(BASE + 4 * i, d, 4'hf);
      checks++;
      if (r !== 2'b00 || lat != 1) begin
        errors++;
        $display("FAIL fill_%0d got resp %b lat %0d exp resp 00 lat 1", i, r, lat);
      end
    end
  endtask

  task automatic test_t1();
    logic [1:0]  r;
    logic [31:0] d;
    int          lat;
    wr_bus(BASE + 32'h10, 32'hDEAD_BEEF, 4'hf, 0, r, lat);
    model_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hf);
    checks++;
    if (r !== 2'b00 || lat != 1) begin
      errors++;
      $display("FAIL t1_write got resp %b lat %0d exp resp 00 lat 1", r, lat);
    end
    rd_bus(BASE + 32'h10, 0, d, r, lat);
    checks++;
    if (d !== 32'hDEAD_BEEF || r !== 2'b00 || lat != 2) begin
      errors++;
      $display("FAIL t1_read got %h/%b lat %0d exp deadbeef/00 lat 2", d, r, lat);
    end
  endtask

  task automatic test_w_first();
    logic [1:0]  r;
    logic [31:0] d;
    int          lat;
    axi.wvalid = 1'b1;
    axi.wdata  = 32'h0000_AA00;
    axi.wstrb  = 4'b0010;
    checks++;
    if (axi.wready !== 1'b1) begin
      errors++;
      $display("FAIL t2_wready_idle got %b exp 1", axi.wready);
    end
    tick();
    axi.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (axi.wready !== 1'b0 || axi.bvalid !== 1'b0) begin
        errors++;
        $display("FAIL t2_w_held got wready %b bvalid %b exp 0 0", axi.wready, axi.bvalid);
      end
      if (i < 2) tick();
    end
    axi.awvalid = 1'b1;
    axi.awaddr  = BASE + 32'h10;
    tick();
    axi.awvalid = 1'b0;
    checks++;
    if (axi.bvalid !== 1'b1 || axi.bresp !== 2'b00) begin
      errors++;
      $display("FAIL t2_b got bvalid %b bresp %b exp 1 00", axi.bvalid, axi.bresp);
    end
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    model_write(BASE + 32'h10, 32'h0000_AA00, 4'b0010);
    rd_bus(BASE + 32'h10, 0, d, r, lat);
    checks++;
    if (d !== 32'hDEAD_AAEF || d !== model_read(BASE + 32'h10)) begin
      errors++;
      $display("FAIL t2_read got %h exp deadaaef", d);
    end
  endtask

  task automatic test_oor();
    logic [31:0] addrs [5];
    logic [1:0]  r;
    logic [31:0] d;
    logic [31:0] wd;
    int          lat;
    addrs[0] = BASE + 4 * NW;
    addrs[1] = BASE - 4;
    addrs[2] = 32'hFFFF_FFFC;
    addrs[3] = BASE + 4 * (NW - 1);
    addrs[4] = BASE + 4 * NW + 3;
    for (int i = 0; i < 5; i++) begin
      wd = $urandom();
      wr_bus(addrs[i], wd, 4'hf, 0, r, lat);
      model_write(addrs[i], wd, 4'hf);
      checks++;
      if (r !== exp_resp(addrs[i])) begin
        errors++;
        $display("FAIL oor_bresp_%0d got %b exp %b", i, r, exp_resp(addrs[i]));
      end
      rd_bus(addrs[i], 0, d, r, lat);
      checks++;
      if (d !== model_read(addrs[i]) || r !== exp_resp(addrs[i])) begin
        errors++;
        $display("FAIL oor_read_%0d got %h/%b exp %h/%b", i, d, r,
                 model_read(addrs[i]), exp_resp(addrs[i]));
      end
    end
    rd_bus(BASE, 0, d, r, lat);
    checks++;
    if (d !== model[0] || r !== 2'b00) begin
      errors++;
      $display("FAIL oor_word0 got %h/%b exp %h/00", d, r, model[0]);
    end
  endtask

  task automatic test_b_stall();
    logic [31:0] a1, a2, d1, d2, d;
    logic [1:0]  r;
    int          lat;
    a1 = rand_in_addr();
    a2 = rand_in_addr();
    d1 = $urandom();
    d2 = $urandom();
    axi.awvalid = 1'b1;
    axi.awaddr  = a1;
    axi.wvalid  = 1'b1;
    axi.wdata   = d1;
    axi.wstrb   = 4'hf;
    tick();
    model_write(a1, d1, 4'hf);
    axi.wvalid = 1'b0;
    axi.awaddr = a2;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({axi.bvalid, axi.bresp, axi.awready, axi.wready} !== 5'b1_00_00) begin
        errors++;
        $display("FAIL b_stall_%0d got bvalid %b bresp %b awready %b wready %b exp 1 00 0 0",
                 i, axi.bvalid, axi.bresp, axi.awready, axi.wready);
      end
      tick();
    end
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    checks++;
    if (axi.awready !== 1'b1 || axi.bvalid !== 1'b0) begin
      errors++;
      $display("FAIL b_after_hs got awready %b bvalid %b exp 1 0", axi.awready, axi.bvalid);
    end
    tick();
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b1;
    axi.wdata   = d2;
    tick();
    axi.wvalid = 1'b0;
    model_write(a2, d2, 4'hf);
    checks++;
    if (axi.bvalid !== 1'b1 || axi.bresp !== 2'b00) begin
      errors++;
      $display("FAIL b_second got bvalid %b bresp %b exp 1 00", axi.bvalid, axi.bresp);
    end
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    rd_bus(a2, 0, d, r, lat);
    checks++;
    if (d !== model_read(a2)) begin
      errors++;
      $display("FAIL b_second_read got %h exp %h", d, model_read(a2));
    end
  endtask

  task automatic test_r_stall();
    logic [31:0] a;
    a = rand_in_addr();
    axi.arvalid = 1'b1;
    axi.araddr  = a;
    tick();
    axi.arvalid = 1'b0;
    checks++;
    if (axi.rvalid !== 1'b0 || axi.arready !== 1'b0) begin
      errors++;
      $display("FAIL r_mem got rvalid %b arready %b exp 0 0", axi.rvalid, axi.arready);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (axi.rvalid !== 1'b1 || axi.arready !== 1'b0 || axi.rdata !== model_read(a)) begin
        errors++;
        $display("FAIL r_stall_%0d got rvalid %b arready %b rdata %h exp 1 0 %h",
                 i, axi.rvalid, axi.arready, axi.rdata, model_read(a));
      end
      tick();
    end
    axi.rready = 1'b1;
    tick();
    axi.rready = 1'b0;
    checks++;
    if (axi.rvalid !== 1'b0 || axi.arready !== 1'b1) begin
      errors++;
      $display("FAIL r_after_hs got rvalid %b arready %b exp 0 1", axi.rvalid, axi.arready);
    end
  endtask

  task automatic test_rw_order();
    logic [31:0] a, dn, old, d;
    logic [1:0]  r;
    int          lat;
    // Write committed in the AR handshake cycle is visible to that read.
    a  = rand_in_addr();
    dn = $urandom();
    axi.arvalid = 1'b1;
    axi.araddr  = a;
    axi.awvalid = 1'b1;
    axi.awaddr  = a;
    axi.wvalid  = 1'b1;
    axi.wdata   = dn;
    axi.wstrb   = 4'hf;
    tick();
    model_write(a, dn, 4'hf);
    axi.arvalid = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b1;
    tick();
    axi.bready = 1'b0;
    checks++;
    if (axi.rvalid !== 1'b1 || axi.rdata !== model_read(a)) begin
      errors++;
      $display("FAIL order_ar_cycle got rvalid %b rdata %h exp 1 %h",
               axi.rvalid, axi.rdata, model_read(a));
    end
    axi.rready = 1'b1;
    tick();
    axi.rready = 1'b0;
    // Write committed during the read's RAM cycle is not visible to that read.
    a   = rand_in_addr();
    dn  = $urandom();
    old = model_read(a);
    axi.arvalid = 1'b1;
    axi.araddr  = a;
    tick();
    axi.arvalid = 1'b0;
    axi.awvalid = 1'b1;
    axi.awaddr  = a;
    axi.wvalid  = 1'b1;
    axi.wdata   = dn;
    axi.wstrb   = 4'hf;
    tick();
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    model_write(a, dn, 4'hf);
    checks++;
    if (axi.rvalid !== 1'b1 || axi.rdata !== old) begin
      errors++;
      $display("FAIL order_rmem got rvalid %b rdata %h exp 1 %h", axi.rvalid, axi.rdata, old);
    end
    axi.bready = 1'b1;
    axi.rready = 1'b1;
    tick();
    axi.bready = 1'b0;
    axi.rready = 1'b0;
    rd_bus(a, 0, d, r, lat);
    checks++;
    if (d !== model_read(a)) begin
      errors++;
      $display("FAIL order_reread got %h exp %h", d, model_read(a));
    end
  endtask

  task automatic test_concurrent();
    logic [31:0] wa, ra, wd, rd, exp_d;
    logic [1:0]  wr, rr;
    int          wl, rl;
    for (int i = 0; i < 10; i++) begin
      wa = BASE + 4 * $urandom_range(0, NW - 1);
      ra = BASE + 4 * ((widx(wa) + 1 + $urandom_range(0, NW - 2)) % NW);
      wd = $urandom();
      exp_d = model_read(ra);
      fork
        wr_bus(wa, wd, 4'hf, 0, wr, wl);
        rd_bus(ra, 0, rd, rr, rl);
      join
      model_write(wa, wd, 4'hf);
      checks++;
      if (wl != 1 || rl != 2 || wr !== 2'b00 || rr !== 2'b00 || rd !== exp_d) begin
        errors++;
        $display("FAIL concurrent_%0d got wlat %0d rlat %0d bresp %b rresp %b rdata %h exp 1 2 00 00 %h",
                 i, wl, rl, wr, rr, rd, exp_d);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, got;
    logic [3:0]  s;
    logic [1:0]  r;
    int          lat;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom();
        if (in_rng(a)) a = BASE + 4 * NW + (a & 32'hff);
      end else begin
        a = rand_in_addr();
      end
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom();
        s = 4'($urandom());
        wr_bus(a, d, s, $urandom_range(0, 2), r, lat);
        model_write(a, d, s);
        checks++;
        if (r !== exp_resp(a) || lat != 1) begin
          errors++;
          $display("FAIL rand_wr_%0d addr %h got %b lat %0d exp %b lat 1",
                   i, a, r, lat, exp_resp(a));
        end
      end else begin
        rd_bus(a, $urandom_range(0, 2), got, r, lat);
        checks++;
        if (got !== model_read(a) || r !== exp_resp(a) || lat != 2) begin
          errors++;
          $display("FAIL rand_rd_%0d addr %h got %h/%b lat %0d exp %h/%b lat 2",
                   i, a, got, r, lat, model_read(a), exp_resp(a));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, d, got;
    logic [1:0]  r;
    int          lat;
    a = rand_in_addr();
    d = $urandom();
    axi.awvalid = 1'b1;
    axi.awaddr  = a;
    axi.wvalid  = 1'b1;
    axi.wdata   = d;
    axi.wstrb   = 4'hf;
    axi.arvalid = 1'b1;
    axi.araddr  = a;
    tick();
    model_write(a, d, 4'hf);
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.arvalid = 1'b0;
    checks++;
    if (axi.bvalid !== 1'b1 || axi.arready !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre got bvalid %b arready %b exp 1 0", axi.bvalid, axi.arready);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (axi.bvalid !== 1'b0 || axi.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got bvalid %b rvalid %b exp 0 0", axi.bvalid, axi.rvalid);
    end
    tick();
    tick();
    checks++;
    if (axi.bvalid !== 1'b0 || axi.rvalid !== 1'b0 || axi.rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_held got bvalid %b rvalid %b rdata %h exp 0 0 0",
               axi.bvalid, axi.rvalid, axi.rdata);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({axi.awready, axi.wready, axi.arready} !== 3'b111) begin
      errors++;
      $display("FAIL rst_readys got %b exp 111", {axi.awready, axi.wready, axi.arready});
    end
    rd_bus(a, 0, got, r, lat);
    checks++;
    if (got !== model_read(a) || r !== 2'b00 || lat != 2) begin
      errors++;
      $display("FAIL rst_ram_kept got %h/%b lat %0d exp %h/00 lat 2", got, r, lat, model_read(a));
    end
    a = rand_in_addr();
    d = $urandom();
    wr_bus(a, d, 4'b1001, 0, r, lat);
    model_write(a, d, 4'b1001);
    rd_bus(a, 0, got, r, lat);
    checks++;
    if (got !== model_read(a) || r !== 2'b00) begin
      errors++;
      $display("FAIL rst_fresh got %h/%b exp %h/00", got, r, model_read(a));
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    axi.awvalid = 1'b0;
    axi.awaddr  = '0;
    axi.awprot  = '0;
    axi.wvalid  = 1'b0;
    axi.wdata   = '0;
    axi.wstrb   = '0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0;
    axi.araddr  = '0;
    axi.arprot  = '0;
    axi.rready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    test_reset();
    test_fill();
    test_t1();
    test_w_first();
    test_oor();
    test_b_stall();
    test_r_stall();
    test_rw_order();
    test_concurrent();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
